// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light controller with a pedestrian walk phase.
// Round-robin arbitration among road A, road B and pending pedestrian requests.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 6,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       Pb,
  output logic       Ga,
  output logic       Ya,
  output logic       Ra,
  output logic       Gb,
  output logic       Yb,
  output logic       Rb,
  output logic       Walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    GREEN_A  = 3'd1,
    YELLOW_A = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4,
    WALK     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRV_A = 2'd0,
    SRV_B = 2'd1,
    SRV_P = 2'd2
  } srv_t;

  // A misconfigured GREEN_MIN above GREEN_MAX collapses to GREEN_MAX.
  localparam int GMIN_EFF = (GREEN_MIN > GREEN_MAX) ? GREEN_MAX : GREEN_MIN;

  localparam logic [CW-1:0] GMIN_LAST = CW'(GMIN_EFF - 1);
  localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(ALL_RED_T - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK_T - 1);

  state_t        state;
  state_t        state_next;
  state_t        rr_next;
  logic [CW-1:0] cnt;
  logic          ped_pend;
  srv_t          last_served;
  logic          entering;

  assign entering = (state_next != state);

  // State register and the per-state bookkeeping that rides on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALL_RED;
      cnt         <= '0;
      ped_pend    <= 1'b0;
      last_served <= SRV_P;
    end else begin
      state <= state_next;
      cnt   <= entering ? '0 : cnt + CW'(1);
      if (entering && state_next == WALK)
        ped_pend <= 1'b0;
      else if (Pb && state != WALK)
        ped_pend <= 1'b1;
      if (entering) begin
        case (state_next)
          GREEN_A: last_served <= SRV_A;
          GREEN_B: last_served <= SRV_B;
          WALK:    last_served <= SRV_P;
          default: last_served <= last_served;
        endcase
      end
    end
  end

  // Round-robin pick: first requester after last_served in the order A->B->P.
  always_comb begin
    rr_next = GREEN_A;
    case (last_served)
      SRV_A: begin
        if (Sb)            rr_next = GREEN_B;
        else if (ped_pend) rr_next = WALK;
        else if (Sa)       rr_next = GREEN_A;
        else               rr_next = GREEN_B;
      end
      SRV_B: begin
        if (ped_pend)      rr_next = WALK;
        else if (Sa)       rr_next = GREEN_A;
        else if (Sb)       rr_next = GREEN_B;
        else               rr_next = GREEN_A;
      end
      default: begin
        if (Sa)            rr_next = GREEN_A;
        else if (Sb)       rr_next = GREEN_B;
        else if (ped_pend) rr_next = WALK;
        else               rr_next = GREEN_A;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ALL_RED:  if (cnt == AR_LAST) state_next = rr_next;
      GREEN_A:  if ((cnt >= GMIN_LAST && (Sb || ped_pend)) || cnt == GMAX_LAST)
                  state_next = YELLOW_A;
      YELLOW_A: if (cnt == YEL_LAST) state_next = ALL_RED;
      GREEN_B:  if ((cnt >= GMIN_LAST && (Sa || ped_pend)) || cnt == GMAX_LAST)
                  state_next = YELLOW_B;
      YELLOW_B: if (cnt == YEL_LAST) state_next = ALL_RED;
      WALK:     if (cnt == WALK_LAST) state_next = ALL_RED;
      default:  state_next = ALL_RED;
    endcase
  end

  // Moore lamp decode from the state register only.
  always_comb begin
    Ga   = 1'b0;
    Ya   = 1'b0;
    Ra   = 1'b0;
    Gb   = 1'b0;
    Yb   = 1'b0;
    Rb   = 1'b0;
    Walk = 1'b0;
    case (state)
      GREEN_A:  begin Ga = 1'b1; Rb = 1'b1; end
      YELLOW_A: begin Ya = 1'b1; Rb = 1'b1; end
      GREEN_B:  begin Gb = 1'b1; Ra = 1'b1; end
      YELLOW_B: begin Yb = 1'b1; Ra = 1'b1; end
      WALK:     begin Ra = 1'b1; Rb = 1'b1; Walk = 1'b1; end
      default:  begin Ra = 1'b1; Rb = 1'b1; end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: per-cycle expected phase/lamp
// sequence in a scoreboard queue, popped by a negedge monitor.
module tb_traffic_phase_scheduler;

  localparam int W = 10;

  localparam logic [2:0] P_AR = 3'd0;
  localparam logic [2:0] P_GA = 3'd1;
  localparam logic [2:0] P_YA = 3'd2;
  localparam logic [2:0] P_GB = 3'd3;
  localparam logic [2:0] P_YB = 3'd4;
  localparam logic [2:0] P_WK = 3'd5;

  logic       clk;
  logic       reset;
  logic       Sa;
  logic       Sb;
  logic       Pb;
  logic       Ga;
  logic       Ya;
  logic       Ra;
  logic       Gb;
  logic       Yb;
  logic       Rb;
  logic       Walk;
  logic [2:0] phase;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_seq    = 0;

  traffic_phase_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .Sa    (Sa),
    .Sb    (Sb),
    .Pb    (Pb),
    .Ga    (Ga),
    .Ya    (Ya),
    .Ra    (Ra),
    .Gb    (Gb),
    .Yb    (Yb),
    .Rb    (Rb),
    .Walk  (Walk),
    .phase (phase)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] lamp_vec(input logic [2:0] ph);
    // {phase, Ga, Ya, Ra, Gb, Yb, Rb, Walk}
    case (ph)
      P_GA:    return {ph, 7'b1000010};
      P_YA:    return {ph, 7'b0100010};
      P_GB:    return {ph, 7'b0011000};
      P_YB:    return {ph, 7'b0010100};
      P_WK:    return {ph, 7'b0010011};
      default: return {ph, 7'b0010010};
    endcase
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {phase, Ga, Ya, Ra, Gb, Yb, Rb, Walk};
  endfunction

  // Driver tasks
  task automatic push(input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lamp_vec(ph));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(2);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor plus per-cycle lamp invariants
  initial begin
    logic [W-1:0] exp_v;
    forever begin
      @(negedge clk);
      n_checks++;
      if (($countones({Ga, Ya, Ra}) != 1) || ($countones({Gb, Yb, Rb}) != 1) ||
          ($countones({Ga, Gb, Walk}) > 1)) begin
        n_fail++;
        $display("FAIL lamp_invariant t=%0t: got Ga%bYa%bRa%b Gb%bYb%bRb%b Walk%b, required one lamp per road and no conflicting go",
                 $time, Ga, Ya, Ra, Gb, Yb, Rb, Walk);
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_seq++;
        n_checks++;
        if (dut_vec() !== exp_v) begin
          n_fail++;
          $display("FAIL seq[%0d] t=%0t: got phase=%0d lamps=%b, required phase=%0d lamps=%b",
                   n_seq, $time, phase, dut_vec() & 10'h07f, exp_v[W-1:7], exp_v[6:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    Sa = 1'b0;
    Sb = 1'b0;
    Pb = 1'b0;
    #13;
    n_checks++;
    if (dut_vec() !== lamp_vec(P_AR)) begin
      n_fail++;
      $display("FAIL reset_state: got %b, required %b", dut_vec(), lamp_vec(P_AR));
    end

    // Only road A requests: green held to GREEN_MAX, then A again.
    Sa = 1'b1;
    release_reset();
    push(P_AR, 2); push(P_GA, 32); push(P_YA, 3); push(P_AR, 2); push(P_GA, 1);
    wait_drain(80, "only_a");

    // Both roads requesting: alternate at GREEN_MIN.
    assert_reset();
    Sa = 1'b1;
    Sb = 1'b1;
    release_reset();
    push(P_AR, 2); push(P_GA, 8); push(P_YA, 3); push(P_AR, 2);
    push(P_GB, 8); push(P_YB, 3); push(P_AR, 2);
    push(P_GA, 8); push(P_YA, 3); push(P_AR, 2); push(P_GB, 1);
    wait_drain(80, "both");

    // No requests: alternate at GREEN_MAX.
    assert_reset();
    Sa = 1'b0;
    Sb = 1'b0;
    release_reset();
    push(P_AR, 2); push(P_GA, 32); push(P_YA, 3); push(P_AR, 2);
    push(P_GB, 32); push(P_YB, 3); push(P_AR, 2); push(P_GA, 1);
    wait_drain(120, "idle");

    // Pedestrian pulse in GREEN_A cycle 2; a press during WALK must not re-arm.
    assert_reset();
    Sa = 1'b1;
    Sb = 1'b0;
    release_reset();
    push(P_AR, 2); push(P_GA, 8); push(P_YA, 3); push(P_AR, 2);
    push(P_WK, 6); push(P_AR, 2); push(P_GA, 32); push(P_YA, 3); push(P_AR, 2);
    push(P_GA, 1);
    wait_cycles(3);
    Pb = 1'b1;
    wait_cycles(1);
    Pb = 1'b0;
    wait_cycles(13);
    Pb = 1'b1;
    wait_cycles(1);
    Pb = 1'b0;
    wait_drain(100, "ped");

    // Reset mid GREEN_B (cnt=5) with a pedestrian request pending.
    assert_reset();
    Sa = 1'b0;
    Sb = 1'b0;
    release_reset();
    push(P_AR, 2); push(P_GA, 32); push(P_YA, 3); push(P_AR, 2); push(P_GB, 5);
    wait_cycles(41);
    Pb = 1'b1;
    wait_cycles(1);
    Pb = 1'b0;
    wait_cycles(2);
    wait_drain(0, "pre_reset");
    n_checks++;
    if (phase !== P_GB) begin
      n_fail++;
      $display("FAIL pre_reset_phase: got %0d, required %0d", phase, P_GB);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({phase, Gb, Ra, Rb} !== {P_AR, 3'b011}) begin
      n_fail++;
      $display("FAIL async_reset: got phase=%0d Gb=%b Ra=%b Rb=%b, required phase=0 Gb=0 Ra=1 Rb=1",
               phase, Gb, Ra, Rb);
    end
    @(posedge clk);
    #1;
    release_reset();
    push(P_AR, 2); push(P_GA, 32); push(P_YA, 3); push(P_AR, 2); push(P_GB, 1);
    wait_drain(80, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 8: minimum green cycles per road before it may yield to a competing request.
REQ-002 Parameter GREEN_MAX, default 32: maximum green cycles per road, regardless of requests.
REQ-003 Parameter YELLOW_T, default 3: yellow duration in cycles.
REQ-004 Parameter ALL_RED_T, default 2: all-red clearance duration in cycles.
REQ-005 Parameter WALK_T, default 6: pedestrian walk duration in cycles.
REQ-006 Parameter CW, default 6: phase counter width; must hold GREEN_MAX-1.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 Sa  in  1  road A vehicle sensor, level.
REQ-010 Sb  in  1  road B vehicle sensor, level.
REQ-011 Pb  in  1  pedestrian button, may be a 1-cycle pulse.
REQ-012 Ga, Ya, Ra  out  1 each  road A lamps.
REQ-013 Gb, Yb, Rb  out  1 each  road B lamps.
REQ-014 Walk  out  1  pedestrian walk lamp.
REQ-015 phase  out  3  current state encoding: ALL_RED=0, GREEN_A=1, YELLOW_A=2, GREEN_B=3, YELLOW_B=4, WALK=5.

Function
REQ-016 States: ALL_RED, GREEN_A, YELLOW_A, GREEN_B, YELLOW_B, WALK; lamps are Moore outputs decoded from the state register only.
REQ-017 Lamps: GREEN_A -> Ga, Rb; YELLOW_A -> Ya, Rb; GREEN_B -> Gb, Ra; YELLOW_B -> Yb, Ra; WALK and ALL_RED -> Ra, Rb (Walk=1 only in WALK); all other lamps 0.
REQ-018 Invariant: exactly one of Gx/Yx/Rx is 1 per road; at most one of Ga, Gb, Walk is 1; never green on both roads.
REQ-019 Counter cnt clears to 0 on every state entry and increments by 1 each cycle within a state; no wrap within any legal state.
REQ-020 A timed state of duration T occupies exactly T cycles (exit on the edge where cnt==T-1).
REQ-021 ped_pend sets on any cycle with Pb=1 outside WALK, clears on entry to WALK; Pb during WALK is ignored.
REQ-022 GREEN_A exits to YELLOW_A when (cnt>=GREEN_MIN-1 and (Sb or ped_pend)) or cnt==GREEN_MAX-1; GREEN_B symmetric using Sa.
REQ-023 YELLOW_x -> ALL_RED after YELLOW_T; WALK -> ALL_RED after WALK_T.
REQ-024 At the last ALL_RED cycle the next phase is chosen round-robin: first requester (A=Sa, B=Sb, P=ped_pend) in cyclic order A->B->P after last_served.
REQ-025 If no requester at that point: next = B if last_served==A, else A.
REQ-026 last_served updates on entry to GREEN_A, GREEN_B or WALK.
REQ-027 Sensor changes during YELLOW, ALL_RED or WALK never shorten those states.
REQ-028 GREEN_MIN > GREEN_MAX is a configuration error; design behaves as if GREEN_MIN==GREEN_MAX.

Reset
REQ-029 reset=1 forces immediately, without a clock edge: state=ALL_RED, cnt=0, ped_pend=0, last_served=P, Ra=Rb=1, all other lamps 0, phase=0.
REQ-030 Reset asserted mid-phase aborts it; after release ALL_RED runs a full ALL_RED_T before arbitration.

Verification (defaults)
REQ-031 Release reset, Sa=1, Sb=0, Pb=0 -> 2 cycles all-red, Ga=1 for 32 cycles, Ya 3, all-red 2, Ga again.
REQ-032 Sa=Sb=1 constant -> Ga 8, Ya 3, red 2, Gb 8, Yb 3, red 2, repeating.
REQ-033 Sa=1, Sb=0, Pb pulse on GREEN_A cycle 2 -> Ga 8 cycles, Ya 3, all-red 2, Walk 6 with Ra=Rb=1, all-red 2, then Ga.
REQ-034 Sa=Sb=0, no Pb -> Ga 32, Ya 3, red 2, Gb 32, Yb 3, red 2, alternating.
REQ-035 reset asserted asynchronously at GREEN_B cnt=5 -> Gb=0, Ra=Rb=1 before next clk edge; after release, 2 all-red cycles then arbitration with last_served=P.
REQ-036 All runs: checker asserts REQ-018 every cycle and Pb during WALK leaves ped_pend=0 on WALK exit.
